// File: rtl/ex_mem_pkg.sv
// Shared types for the EX/MEM pipeline boundary: state encoding,
// default widths, default load/store opcodes and the entry layout.
package ex_mem_pkg;

    localparam int XLEN_DEF   = 32;
    localparam int REG_AW_DEF = 5;
    localparam int OP_W_DEF   = 4;
    localparam int WB_W_DEF   = 2;

    localparam logic [OP_W_DEF-1:0] OP_LOAD_DEF  = 4'b0101;
    localparam logic [OP_W_DEF-1:0] OP_STORE_DEF = 4'b0110;

    // Encoding is {main_valid, skid_valid}; 2'b01 is unreachable.
    typedef enum logic [1:0] {
        EMPTY = 2'b00,
        FULL  = 2'b10,
        SKID  = 2'b11
    } state_t;

    typedef struct packed {
        logic [WB_W_DEF-1:0]   wb;
        logic                  mem_rd;
        logic                  mem_wr;
        logic [OP_W_DEF-1:0]   op;
        logic [XLEN_DEF-1:0]   alu;
        logic [XLEN_DEF-1:0]   sdata;
        logic [REG_AW_DEF-1:0] rd;
    } entry_t;

    localparam int ENTRY_W_DEF = $bits(entry_t);

endpackage

// File: rtl/ex_mem_slot.sv
// One EX/MEM entry register: async clear, loads only when enabled.
module ex_mem_slot #(
    parameter int W = 1
) (
    input  logic         clk_i,
    input  logic         rst_i,
    input  logic         ld_i,
    input  logic [W-1:0] d_i,
    output logic [W-1:0] q_o
);

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            q_o <= '0;
        end else if (ld_i) begin
            q_o <= d_i;
        end
    end

endmodule

// File: rtl/ex_mem_pipe.sv
// EX/MEM boundary with valid/ready handshake and a 2-entry skid buffer.
// Define EX_MEM_PIPE_PERF_EN to add stall/bubble/flush counters.
module ex_mem_pipe
    import ex_mem_pkg::*;
#(
    parameter int              XLEN     = XLEN_DEF,
    parameter int              REG_AW   = REG_AW_DEF,
    parameter int              OP_W     = OP_W_DEF,
    parameter int              WB_W     = WB_W_DEF,
    parameter logic [OP_W-1:0] OP_LOAD  = OP_LOAD_DEF,
    parameter logic [OP_W-1:0] OP_STORE = OP_STORE_DEF
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              flush_i,
    input  logic              in_valid_i,
    output logic              in_ready_o,
    input  logic [WB_W-1:0]   wb_i,
    input  logic [2:0]        m_i,
    input  logic [OP_W-1:0]   op_i,
    input  logic [XLEN-1:0]   alu_i,
    input  logic [XLEN-1:0]   store_data_i,
    input  logic [REG_AW-1:0] rd_i,
    output logic              out_valid_o,
    input  logic              out_ready_i,
    output logic [WB_W-1:0]   wb_o,
    output logic              mem_read_o,
    output logic              mem_write_o,
    output logic [OP_W-1:0]   op_o,
    output logic [XLEN-1:0]   addr_o,
    output logic [XLEN-1:0]   store_data_o,
    output logic [REG_AW-1:0] fwd_rd_o,
`ifdef EX_MEM_PIPE_PERF_EN
    output logic              fwd_valid_o,
    output logic [31:0]       stall_cnt_o,
    output logic [31:0]       bubble_cnt_o,
    output logic [15:0]       flush_cnt_o
`else
    output logic              fwd_valid_o
`endif
);

    typedef struct packed {
        logic [WB_W-1:0]   wb;
        logic              mem_rd;
        logic              mem_wr;
        logic [OP_W-1:0]   op;
        logic [XLEN-1:0]   alu;
        logic [XLEN-1:0]   sdata;
        logic [REG_AW-1:0] rd;
    } slot_t;

    localparam int SW = $bits(slot_t);

    state_t state_q;
    state_t state_d;
    logic   accept;
    logic   pop;
    logic   main_ld;
    logic   skid_ld;
    logic   main_from_skid;
    logic   dec_rd;
    logic   dec_wr;
    logic   m_unused;
    slot_t  in_ent;
    slot_t  main_d;
    slot_t  main_q;
    slot_t  skid_q;

    assign m_unused = m_i[0];

    assign in_ready_o  = ~state_q[0];
    assign out_valid_o = state_q[1];
    assign accept      = in_valid_i & in_ready_o;
    assign pop         = out_valid_o & out_ready_i;

    // Memory intent is fixed when the entry is captured.
    always_comb begin
        dec_rd = m_i[2];
        dec_wr = m_i[1];
        unique case (1'b1)
            (op_i == OP_LOAD): begin
                dec_rd = 1'b1;
                dec_wr = 1'b0;
            end
            (op_i == OP_STORE): begin
                dec_rd = 1'b0;
                dec_wr = 1'b1;
            end
            default: ;
        endcase
    end

    always_comb begin
        in_ent.wb     = wb_i;
        in_ent.mem_rd = dec_rd;
        in_ent.mem_wr = dec_wr;
        in_ent.op     = op_i;
        in_ent.alu    = alu_i;
        in_ent.sdata  = store_data_i;
        in_ent.rd     = rd_i;
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q <= EMPTY;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        if (flush_i) begin
            state_d = EMPTY;
        end else begin
            unique case (state_q)
                EMPTY: if (accept) state_d = FULL;
                FULL: begin
                    if (accept && !pop) state_d = SKID;
                    else if (!accept && pop) state_d = EMPTY;
                end
                SKID: if (pop) state_d = FULL;
                default: state_d = EMPTY;
            endcase
        end
    end

    // Flush drops both the incoming entry and any skid refill.
    always_comb begin
        main_ld        = 1'b0;
        skid_ld        = 1'b0;
        main_from_skid = 1'b0;
        if (!flush_i) begin
            unique case (state_q)
                EMPTY: main_ld = accept;
                FULL: begin
                    main_ld = accept & pop;
                    skid_ld = accept & ~pop;
                end
                SKID: begin
                    main_ld        = pop;
                    main_from_skid = 1'b1;
                end
                default: ;
            endcase
        end
    end

    assign main_d = main_from_skid ? skid_q : in_ent;

    ex_mem_slot #(.W(SW)) u_main (
        .clk_i (clk_i),
        .rst_i (rst_i),
        .ld_i  (main_ld),
        .d_i   (main_d),
        .q_o   (main_q)
    );

    ex_mem_slot #(.W(SW)) u_skid (
        .clk_i (clk_i),
        .rst_i (rst_i),
        .ld_i  (skid_ld),
        .d_i   (in_ent),
        .q_o   (skid_q)
    );

    assign wb_o         = main_q.wb;
    assign op_o         = main_q.op;
    assign addr_o       = main_q.alu;
    assign store_data_o = main_q.sdata;
    assign fwd_rd_o     = main_q.rd;
    assign mem_read_o   = main_q.mem_rd & out_valid_o;
    assign mem_write_o  = main_q.mem_wr & out_valid_o;
    assign fwd_valid_o  = out_valid_o & main_q.wb[0] & (main_q.rd != '0);

`ifdef EX_MEM_PIPE_PERF_EN
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            stall_cnt_o  <= '0;
            bubble_cnt_o <= '0;
            flush_cnt_o  <= '0;
        end else begin
            if (in_valid_i && !in_ready_o && stall_cnt_o != '1)
                stall_cnt_o <= stall_cnt_o + 32'd1;
            if (!out_valid_o && bubble_cnt_o != '1)
                bubble_cnt_o <= bubble_cnt_o + 32'd1;
            if (flush_i && flush_cnt_o != '1)
                flush_cnt_o <= flush_cnt_o + 16'd1;
        end
    end
`endif

endmodule

// File: tb/tb_ex_mem_pipe.sv
// Self-checking bench for ex_mem_pipe: queue model plus directed vectors.
// Perf counter checks compile in when EX_MEM_PIPE_PERF_EN is defined.
module tb_ex_mem_pipe;
    import ex_mem_pkg::*;

    logic        clk_i = 1'b0;
    logic        rst_i;
    logic        flush_i;
    logic        in_valid_i;
    logic        in_ready_o;
    logic [1:0]  wb_i;
    logic [2:0]  m_i;
    logic [3:0]  op_i;
    logic [31:0] alu_i;
    logic [31:0] store_data_i;
    logic [4:0]  rd_i;
    logic        out_valid_o;
    logic        out_ready_i;
    logic [1:0]  wb_o;
    logic        mem_read_o;
    logic        mem_write_o;
    logic [3:0]  op_o;
    logic [31:0] addr_o;
    logic [31:0] store_data_o;
    logic [4:0]  fwd_rd_o;
    logic        fwd_valid_o;
`ifdef EX_MEM_PIPE_PERF_EN
    logic [31:0] stall_cnt_o;
    logic [31:0] bubble_cnt_o;
    logic [15:0] flush_cnt_o;
`endif

    int checks = 0;
    int errors = 0;

    always #5 clk_i = ~clk_i;

    ex_mem_pipe dut (
        .clk_i        (clk_i),
        .rst_i        (rst_i),
        .flush_i      (flush_i),
        .in_valid_i   (in_valid_i),
        .in_ready_o   (in_ready_o),
        .wb_i         (wb_i),
        .m_i          (m_i),
        .op_i         (op_i),
        .alu_i        (alu_i),
        .store_data_i (store_data_i),
        .rd_i         (rd_i),
        .out_valid_o  (out_valid_o),
        .out_ready_i  (out_ready_i),
        .wb_o         (wb_o),
        .mem_read_o   (mem_read_o),
        .mem_write_o  (mem_write_o),
        .op_o         (op_o),
        .addr_o       (addr_o),
        .store_data_o (store_data_o),
        .fwd_rd_o     (fwd_rd_o),
`ifdef EX_MEM_PIPE_PERF_EN
        .fwd_valid_o  (fwd_valid_o),
        .stall_cnt_o  (stall_cnt_o),
        .bubble_cnt_o (bubble_cnt_o),
        .flush_cnt_o  (flush_cnt_o)
`else
        .fwd_valid_o  (fwd_valid_o)
`endif
    );

    task automatic chk(input string name, input logic [63:0] act,
                       input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    // Model: a FIFO of at most two entries; ready means fewer than two held.
    entry_t q[$];
    entry_t e_m;
    logic   acc_m;
    logic   pop_m;
    longint stall_m;
    longint bubble_m;
    longint flush_m;

    always @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            q.delete();
            stall_m  = 0;
            bubble_m = 0;
            flush_m  = 0;
        end else begin
            acc_m = in_valid_i && (q.size() < 2);
            pop_m = out_ready_i && (q.size() > 0);
            if (in_valid_i && q.size() >= 2) stall_m++;
            if (q.size() == 0) bubble_m++;
            if (flush_i) flush_m++;
            if (flush_i) begin
                q.delete();
            end else begin
                if (pop_m) void'(q.pop_front());
                if (acc_m) begin
                    e_m.wb     = wb_i;
                    e_m.op     = op_i;
                    e_m.alu    = alu_i;
                    e_m.sdata  = store_data_i;
                    e_m.rd     = rd_i;
                    e_m.mem_rd = (op_i == 4'b0101) ? 1'b1 :
                                 (op_i == 4'b0110) ? 1'b0 : m_i[2];
                    e_m.mem_wr = (op_i == 4'b0110) ? 1'b1 :
                                 (op_i == 4'b0101) ? 1'b0 : m_i[1];
                    q.push_back(e_m);
                end
            end
        end
    end

    always @(negedge clk_i) begin
        if (!rst_i) begin
            chk("out_valid", out_valid_o, q.size() > 0);
            chk("in_ready", in_ready_o, q.size() < 2);
            if (q.size() > 0) begin
                chk("wb", wb_o, q[0].wb);
                chk("op", op_o, q[0].op);
                chk("addr", addr_o, q[0].alu);
                chk("sdata", store_data_o, q[0].sdata);
                chk("fwd_rd", fwd_rd_o, q[0].rd);
                chk("mem_read", mem_read_o, q[0].mem_rd);
                chk("mem_write", mem_write_o, q[0].mem_wr);
                chk("fwd_valid", fwd_valid_o,
                    q[0].wb[0] && (q[0].rd != 0));
            end else begin
                chk("bubble_mem_read", mem_read_o, 1'b0);
                chk("bubble_mem_write", mem_write_o, 1'b0);
                chk("bubble_fwd_valid", fwd_valid_o, 1'b0);
            end
`ifdef EX_MEM_PIPE_PERF_EN
            chk("stall_cnt", stall_cnt_o, stall_m);
            chk("bubble_cnt", bubble_cnt_o, bubble_m);
            chk("flush_cnt", flush_cnt_o, flush_m);
`endif
        end
    end

    task automatic step(input logic v, input logic [3:0] op,
                        input logic [31:0] alu, input logic [31:0] sd,
                        input logic [4:0] rd, input logic [1:0] wb,
                        input logic [2:0] m, input logic ordy,
                        input logic fl);
        in_valid_i   = v;
        op_i         = op;
        alu_i        = alu;
        store_data_i = sd;
        rd_i         = rd;
        wb_i         = wb;
        m_i          = m;
        out_ready_i  = ordy;
        flush_i      = fl;
        @(posedge clk_i);
        #1;
    endtask

    task automatic idle(input logic ordy, input logic fl);
        step(1'b0, 4'h0, 32'h0, 32'h0, 5'd0, 2'b00, 3'b000, ordy, fl);
    endtask

    initial begin
        rst_i = 1'b1;
        flush_i = 1'b0;
        in_valid_i = 1'b0;
        out_ready_i = 1'b0;
        wb_i = '0;
        m_i = '0;
        op_i = '0;
        alu_i = '0;
        store_data_i = '0;
        rd_i = '0;
        repeat (2) @(posedge clk_i);
        #1;
        chk("rst_out_valid", out_valid_o, 1'b0);
        chk("rst_in_ready", in_ready_o, 1'b1);
        chk("rst_addr", addr_o, 32'h0);
        chk("rst_wb", wb_o, 2'b00);
        rst_i = 1'b0;

        // Streaming: load then store back to back.
        step(1'b1, 4'b0101, 32'h100, 32'h0, 5'd3, 2'b01, 3'b010, 1'b1, 1'b0);
        chk("ld_read", mem_read_o, 1'b1);
        chk("ld_write", mem_write_o, 1'b0);
        chk("ld_addr", addr_o, 32'h100);
        step(1'b1, 4'b0110, 32'h104, 32'hDEAD, 5'd0, 2'b00, 3'b100,
             1'b1, 1'b0);
        chk("st_write", mem_write_o, 1'b1);
        chk("st_read", mem_read_o, 1'b0);
        chk("st_addr", addr_o, 32'h104);
        chk("st_data", store_data_o, 32'hDEAD);
        // Non-forced ops follow m_i.
        step(1'b1, 4'b0000, 32'h108, 32'h0, 5'd1, 2'b01, 3'b100, 1'b1, 1'b0);
        chk("m_read", mem_read_o, 1'b1);
        step(1'b1, 4'b0011, 32'h10C, 32'h55, 5'd2, 2'b00, 3'b010,
             1'b1, 1'b0);
        chk("m_write", mem_write_o, 1'b1);
        idle(1'b1, 1'b0);
        chk("drain_valid", out_valid_o, 1'b0);

        // Backpressure: A, B fill the pipe, C waits upstream.
        step(1'b1, 4'b0000, 32'hA, 32'h0, 5'd4, 2'b01, 3'b000, 1'b0, 1'b0);
        step(1'b1, 4'b0000, 32'hB, 32'h0, 5'd4, 2'b01, 3'b000, 1'b0, 1'b0);
        chk("bp_ready_low", in_ready_o, 1'b0);
        chk("bp_head_a", addr_o, 32'hA);
        step(1'b1, 4'b0000, 32'hC, 32'h0, 5'd4, 2'b01, 3'b000, 1'b0, 1'b0);
        step(1'b1, 4'b0000, 32'hC, 32'h0, 5'd4, 2'b01, 3'b000, 1'b0, 1'b0);
        chk("bp_hold_a", addr_o, 32'hA);
        step(1'b1, 4'b0000, 32'hC, 32'h0, 5'd4, 2'b01, 3'b000, 1'b1, 1'b0);
        chk("bp_head_b", addr_o, 32'hB);
        chk("bp_ready_back", in_ready_o, 1'b1);
        step(1'b1, 4'b0000, 32'hC, 32'h0, 5'd4, 2'b01, 3'b000, 1'b1, 1'b0);
        chk("bp_head_c", addr_o, 32'hC);
`ifdef EX_MEM_PIPE_PERF_EN
        chk("perf_stall3", stall_cnt_o, 32'd3);
`endif
        idle(1'b1, 1'b0);
        chk("bp_empty", out_valid_o, 1'b0);

        // Flush while FULL drops the store accepted in the same cycle.
        step(1'b1, 4'b0101, 32'h200, 32'h0, 5'd6, 2'b01, 3'b000, 1'b0, 1'b0);
        step(1'b1, 4'b0110, 32'h300, 32'hD, 5'd0, 2'b00, 3'b000, 1'b0, 1'b1);
        chk("fl_valid", out_valid_o, 1'b0);
        chk("fl_write", mem_write_o, 1'b0);
        chk("fl_ready", in_ready_o, 1'b1);
        idle(1'b1, 1'b0);
        chk("fl_no_d", out_valid_o, 1'b0);
        idle(1'b1, 1'b1);
`ifdef EX_MEM_PIPE_PERF_EN
        chk("perf_flush2", flush_cnt_o, 16'd2);
        chk("perf_stall_kept", stall_cnt_o, 32'd3);
`endif

        // Forwarding qualification.
        step(1'b1, 4'b0000, 32'h0, 32'h0, 5'd0, 2'b01, 3'b000, 1'b1, 1'b0);
        chk("fwd_rd0", fwd_valid_o, 1'b0);
        step(1'b1, 4'b0000, 32'h0, 32'h0, 5'd5, 2'b01, 3'b000, 1'b1, 1'b0);
        chk("fwd_rd5", fwd_valid_o, 1'b1);
        chk("fwd_rd5_idx", fwd_rd_o, 5'd5);
        idle(1'b1, 1'b0);
        chk("fwd_bubble", fwd_valid_o, 1'b0);

        // Asynchronous reset while SKID.
        step(1'b1, 4'b0101, 32'h400, 32'h0, 5'd7, 2'b01, 3'b000, 1'b0, 1'b0);
        step(1'b1, 4'b0101, 32'h404, 32'h0, 5'd8, 2'b01, 3'b000, 1'b0, 1'b0);
        chk("pre_rst_ready", in_ready_o, 1'b0);
        chk("pre_rst_read", mem_read_o, 1'b1);
        rst_i = 1'b1;
        #1;
        chk("arst_valid", out_valid_o, 1'b0);
        chk("arst_ready", in_ready_o, 1'b1);
        chk("arst_read", mem_read_o, 1'b0);
        chk("arst_write", mem_write_o, 1'b0);
`ifdef EX_MEM_PIPE_PERF_EN
        chk("arst_stall", stall_cnt_o, 32'd0);
`endif
        in_valid_i = 1'b0;
        @(posedge clk_i);
        #1;
        rst_i = 1'b0;
        idle(1'b1, 1'b0);
        idle(1'b1, 1'b0);

        $display("Simulation finished: %0d checks, %0d errors",
                 checks, errors);
        $finish;
    end

endmodule

// File: doc/ex_mem_pipe.md
Name: ex_mem_pipe

Overview:
- Parametrised EX/MEM pipeline boundary for the 5-stage core, replacing the fixed-width, stall-only EX/MEM latch.
- Carries the WB control, memory control, operation code, ALU result (memory address), store data and destination register from EX to MEM.
- Uses a valid/ready handshake with a 2-entry skid buffer, so in_ready_o is a registered signal.
- Adds flush (bubble insertion), gating of memory strobes on bubbles, and forwarding-valid qualification.

Parameters:
- XLEN, 32, width of the ALU result and store data.
- REG_AW, 5, destination register index width.
- OP_W, 4, operation code width.
- WB_W, 2, writeback control width; bit 0 is RegWrite.
- OP_LOAD, 4'b0101, operation code that forces a memory read.
- OP_STORE, 4'b0110, operation code that forces a memory write.

Ports:
- clk_i  in  1  clock; all state updates on the rising edge.
- rst_i  in  1  asynchronous, active-high reset.
- flush_i  in  1  discard all held entries; the input in the same cycle is dropped.
- in_valid_i  in  1  EX presents an entry.
- in_ready_o  out  1  pipe can accept; registered, equals NOT skid_valid.
- wb_i  in  WB_W  WB control.
- m_i  in  3  memory control; [2] read, [1] write, [0] reserved.
- op_i  in  OP_W  operation code.
- alu_i  in  XLEN  ALU result / memory address.
- store_data_i  in  XLEN  forwarded rs2 value.
- rd_i  in  REG_AW  destination register (instr[11:7]).
- out_valid_o  out  1  MEM entry valid.
- out_ready_i  in  1  MEM consumes the entry.
- wb_o  out  WB_W  WB control of the head entry.
- mem_read_o  out  1  data memory read strobe.
- mem_write_o  out  1  data memory write strobe.
- op_o  out  OP_W  operation code of the head entry.
- addr_o  out  XLEN  data memory address.
- store_data_o  out  XLEN  data memory write data.
- fwd_rd_o  out  REG_AW  head entry rd, for the forwarding unit.
- fwd_valid_o  out  1  out_valid_o AND wb_o[0] AND (fwd_rd_o != 0).

Behaviour:
- Reset: every register clears to 0 (out_valid_o = 0, all payload outputs 0, skid empty, in_ready_o = 1). Reset is asynchronous and overrides any transfer in flight.
- Accept condition: in_valid_i AND in_ready_o. Pop condition: out_valid_o AND out_ready_i. Latency from accept to out_valid_o is 1 cycle.
- Memory decode happens at accept time and is stored with the entry:
  - op_i == OP_LOAD gives read = 1, write = 0.
  - op_i == OP_STORE gives read = 0, write = 1.
  - Any other op gives read = m_i[2], write = m_i[1].
  - The decoded bits are held in the entry; the decode is not repeated on output.
- mem_read_o and mem_write_o equal the stored bits AND out_valid_o, so they are 0 on any bubble.
- FSM on {main_valid, skid_valid}: EMPTY(00), FULL(10), SKID(11). State 01 is illegal.
  - EMPTY: accept moves the entry to main and goes to FULL.
  - FULL: accept with pop reloads main from the input and stays FULL. Pop only goes to EMPTY. Accept without pop writes the skid and goes to SKID; in_ready_o drops the next cycle.
  - SKID: in_ready_o = 0 and no accept. Pop moves skid to main and goes to FULL.
- Payload registers load only on the transfers above; otherwise they hold. Hold on stall is therefore implicit.
- Flush: at the next edge main_valid = 0 and skid_valid = 0 (state EMPTY) and in_ready_o = 1.
  - Flush beats a simultaneous accept or pop: the popped entry counts as consumed by MEM this cycle, and the accepted entry is lost.
  - Payload registers need not clear on flush, but strobes are gated by out_valid_o.
- fwd_rd_o and fwd_valid_o are taken from main only; the skid entry is not visible to forwarding.
- No wrap-around or arithmetic in the block; widths pass straight through.

Optional Feature:
- Macro EX_MEM_PIPE_PERF_EN.
- When defined, three output ports are added:
  - stall_cnt_o [31:0]: counts cycles with in_valid_i AND NOT in_ready_o.
  - bubble_cnt_o [31:0]: counts cycles with out_valid_o = 0.
  - flush_cnt_o [15:0]: counts cycles with flush_i = 1.
  - All three saturate at all-ones, reset to 0 on rst_i, and are not cleared by flush_i.
- When not defined, these ports and the counters do not exist; all other behaviour is identical.

Decomposition:
- Package ex_mem_pkg holds:
  - the state encoding (EMPTY, FULL, SKID);
  - default OP_LOAD and OP_STORE constants;
  - the packed entry struct type {wb, mem_rd, mem_wr, op, alu, sdata, rd}, parametrised by the widths via localparam sizing.
- Sub-module ex_mem_slot is one entry register with an async reset, a load enable and a payload bus; it is instantiated twice (main and skid).
- The FSM and decode live in ex_mem_pipe.

Test Plan:
- Reset mid-stream: rst_i pulsed while in SKID -> out_valid_o = 0, in_ready_o = 1, mem_read_o = 0 and mem_write_o = 0 immediately (asynchronously).
- Streaming with out_ready_i = 1: send op = 0101, alu = 0x100, then op = 0110, alu = 0x104, sdata = 0xDEAD -> the next cycles show mem_read_o = 1 with addr_o = 0x100, then mem_write_o = 1 with addr_o = 0x104 and store_data_o = 0xDEAD. No gaps.
- Backpressure: out_ready_i = 0 while sending A, B, C -> in_ready_o = 0 after B; C is held upstream. Releasing out_ready_i yields A, B, C in order with no loss or duplicate.
- Flush: flush_i = 1 in the cycle store D is accepted while in FULL -> next cycle out_valid_o = 0 and mem_write_o = 0; D never appears.
- Forwarding: wb = 2'b01 with rd = 0, then rd = 5 -> fwd_valid_o = 0, then fwd_valid_o = 1 with fwd_rd_o = 5. A bubble gives fwd_valid_o = 0.
- PERF (with EX_MEM_PIPE_PERF_EN defined): 3 blocked cycles and 2 flush cycles -> stall_cnt_o = 3 and flush_cnt_o = 2; the counters hold their values across a flush.
